// File: rtl/grid_pkg.sv
// grid_pkg: shared grid geometry, grid type and cell-index helper for the Life engine
package grid_pkg;
  localparam int GRID_ROWS = 16;
  localparam int GRID_COLS = 16;
  localparam int GRID_W = GRID_ROWS * GRID_COLS;
  typedef logic [GRID_W-1:0] grid_t;
  function automatic int grid_idx(input int row, input int col);
    return row * GRID_COLS + col;
  endfunction
endpackage

// File: rtl/grid_match_enc.sv
// grid_match_enc: finds the smallest period k whose valid history slot k-1 equals d
//   d      in  W            candidate next generation
//   hist   in  W x DEPTH    stored generations, hist[0] = current
//   valid  in  DEPTH        slot holds a real generation
//   period out PW           smallest matching k, 0 = none
//   hit    out 1            any slot matched
module grid_match_enc
  import grid_pkg::*;
#(
  parameter int W = grid_pkg::GRID_W,
  parameter int DEPTH = 4,
  parameter int PW = $clog2(DEPTH + 1)
) (
  input  logic [W-1:0]     d,
  input  logic [W-1:0]     hist [DEPTH],
  input  logic [DEPTH-1:0] valid,
  output logic [PW-1:0]    period,
  output logic             hit
);
  logic [DEPTH-1:0] eq;
  for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
    assign eq[k] = valid[k] & (d == hist[k]);
  end
  // scan from the deepest slot so the shallowest match overwrites and wins
  always_comb begin
    period = '0;
    for (int k = DEPTH - 1; k >= 0; k--) period = eq[k] ? PW'(k + 1) : period;
  end
  assign hit = |eq;
endmodule

// File: rtl/grid_history_reg.sv
// grid_history_reg: Life generation register with history-based period/extinction detection
//   clk, reset   rising-edge clock, synchronous active-high reset
//   seed, load   initial grid; load reseeds exactly like reset
//   en, d        advance one generation, accepting d
//   q            current generation
//   gen_count    saturating advance count since reset/load
//   period       smallest detected period, 0 = none (sticky while holding)
//   stable       period == 1
//   extinct      q == 0
//   halted       auto-halt engaged, en ignored
module grid_history_reg
  import grid_pkg::*;
#(
  parameter int GRID_W = grid_pkg::GRID_W,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16,
  parameter int AUTO_HALT = 1,
  localparam int PW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GRID_W-1:0] seed,
  input  logic              load,
  input  logic              en,
  input  logic [GRID_W-1:0] d,
  output logic [GRID_W-1:0] q,
  output logic [CNT_W-1:0]  gen_count,
  output logic [PW-1:0]     period,
  output logic              stable,
  output logic              extinct,
  output logic              halted
);
  logic [GRID_W-1:0] hist [DEPTH];
  logic [DEPTH-1:0]  valid;
  logic [PW-1:0]     period_next;
  logic              hit;
  grid_match_enc #(.W(GRID_W), .DEPTH(DEPTH)) u_enc (
    .d      (d),
    .hist   (hist),
    .valid  (valid),
    .period (period_next),
    .hit    (hit)
  );
  // older history contents are left stale on reseed; the valid bits mask them out
  always_ff @(posedge clk) begin
    if (reset | load) begin
      hist[0]   <= seed;
      valid     <= DEPTH'(1);
      gen_count <= '0;
      period    <= '0;
      halted    <= 1'b0;
    end else if (en & ~halted) begin
      for (int i = DEPTH - 1; i > 0; i--) hist[i] <= hist[i-1];
      hist[0]   <= d;
      valid     <= (valid << 1) | DEPTH'(1);
      gen_count <= gen_count + CNT_W'(~&gen_count);
      period    <= period_next;
      halted    <= (AUTO_HALT != 0) & hit;
    end
  end
  assign q       = hist[0];
  assign stable  = period == PW'(1);
  assign extinct = ~|q;
endmodule

// File: tb/tb_grid_history_reg.sv
// tb_grid_history_reg: scoreboard bench for grid_history_reg (auto-halt and free-run/4-bit-count instances)
module tb_grid_history_reg;
  import grid_pkg::*;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic r0 = 1'b0, l0 = 1'b0, e0 = 1'b0, st0, ex0, h0;
  logic r1 = 1'b0, l1 = 1'b0, e1 = 1'b0, st1, ex1, h1;
  grid_t s0 = '0, d0 = '0, q0, s1 = '0, d1 = '0, q1;
  logic [15:0] g0;
  logic [3:0]  g1;
  logic [2:0]  p0, p1;
  grid_history_reg u0 (
    .clk(clk), .reset(r0), .seed(s0), .load(l0), .en(e0), .d(d0), .q(q0),
    .gen_count(g0), .period(p0), .stable(st0), .extinct(ex0), .halted(h0)
  );
  grid_history_reg #(.CNT_W(4), .AUTO_HALT(0)) u1 (
    .clk(clk), .reset(r1), .seed(s1), .load(l1), .en(e1), .d(d1), .q(q1),
    .gen_count(g1), .period(p1), .stable(st1), .extinct(ex1), .halted(h1)
  );
  typedef struct packed {
    logic [3:0][255:0] h;
    logic [2:0]        nv;
    logic [15:0]       gen;
    logic [2:0]        per;
    logic              halt;
  } ms_t;
  typedef struct packed {
    logic        dut;
    grid_t       q;
    logic [15:0] gen;
    logic [2:0]  per;
    logic        st, ex, ha;
  } exp_t;
  ms_t   m [2];
  exp_t  sb [$];
  int    nvec = 0, nmis = 0;
  string tname = "init";
  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s.%s got=%0h exp=%0h", tname, tag, got, exp);
    end
  endtask
  function automatic ms_t mstep(ms_t s, bit rl, bit en, grid_t sd, grid_t dd, logic [15:0] cmax, bit ah);
    logic [2:0] p;
    p = '0;
    if (rl) begin
      s.h[0] = sd; s.nv = 3'd1; s.gen = '0; s.per = '0; s.halt = 1'b0;
    end else if (en && !s.halt) begin
      for (int k = 4; k >= 1; k--) if (k <= int'(s.nv) && dd == s.h[k-1]) p = 3'(k);
      for (int i = 3; i > 0; i--) s.h[i] = s.h[i-1];
      s.h[0] = dd;
      if (s.nv < 3'd4) s.nv = s.nv + 3'd1;
      if (s.gen < cmax) s.gen = s.gen + 16'd1;
      s.per = p;
      s.halt = ah && p != 0;
    end
    return s;
  endfunction
  function automatic grid_t rnd();
    grid_t g;
    for (int i = 0; i < 8; i++) g[i*32 +: 32] = $urandom;
    return g;
  endfunction
  task automatic cyc(input bit w, input bit rst, input bit ld, input bit en, input grid_t sd, input grid_t dd);
    exp_t e;
    r0 = 1'b0; l0 = 1'b0; e0 = 1'b0; r1 = 1'b0; l1 = 1'b0; e1 = 1'b0;
    if (!w) begin r0 = rst; l0 = ld; e0 = en; s0 = sd; d0 = dd; end
    else    begin r1 = rst; l1 = ld; e1 = en; s1 = sd; d1 = dd; end
    m[w] = mstep(m[w], rst | ld, en, sd, dd, w ? 16'd15 : 16'hFFFF, !w);
    e.dut = w; e.q = m[w].h[0]; e.gen = m[w].gen; e.per = m[w].per;
    e.st = m[w].per == 3'd1; e.ex = m[w].h[0] == '0; e.ha = m[w].halt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (!e.dut) begin
      chk("q", q0, e.q); chk("gen", g0, e.gen); chk("period", p0, e.per);
      chk("stable", st0, e.st); chk("extinct", ex0, e.ex); chk("halted", h0, e.ha);
    end else begin
      chk("q", q1, e.q); chk("gen", g1, e.gen); chk("period", p1, e.per);
      chk("stable", st1, e.st); chk("extinct", ex1, e.ex); chk("halted", h1, e.ha);
    end
    r0 = 1'b0; l0 = 1'b0; e0 = 1'b0; r1 = 1'b0; l1 = 1'b0; e1 = 1'b0;
  endtask
  grid_t ga, gb, blk, last, sd;
  initial begin
    ga = '0; gb = '0; blk = '0;
    for (int c = 0; c < 3; c++) ga[grid_idx(1, c)] = 1'b1;
    for (int r = 0; r < 3; r++) gb[grid_idx(r, 1)] = 1'b1;
    blk[grid_idx(0, 0)] = 1'b1; blk[grid_idx(0, 1)] = 1'b1;
    blk[grid_idx(1, 0)] = 1'b1; blk[grid_idx(1, 1)] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tname = "reset";
    cyc(0, 1, 0, 0, grid_t'(8'h0F), '0);
    cyc(1, 1, 0, 0, grid_t'(8'h0F), '0);
    cyc(0, 0, 0, 0, '0, rnd());
    chk("q_const", q0, 256'h0F);
    tname = "blinker";
    cyc(0, 1, 0, 0, ga, '0);
    cyc(0, 0, 0, 1, '0, gb);
    chk("p1_const", p0, 0);
    cyc(0, 0, 0, 1, '0, ga);
    chk("p2_const", p0, 2);
    chk("halt_const", h0, 1);
    cyc(0, 0, 0, 1, '0, gb);
    cyc(0, 0, 0, 1, '0, rnd());
    chk("frozen_q", q0, ga);
    tname = "block";
    cyc(1, 1, 0, 0, blk, '0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 1, '0, blk);
    chk("gen_const", g1, 4);
    chk("stable_const", st1, 1);
    tname = "extinct";
    cyc(1, 1, 0, 0, grid_t'(1), '0);
    cyc(1, 0, 0, 1, '0, '0);
    chk("ex_const", ex1, 1);
    cyc(1, 0, 0, 1, '0, '0);
    chk("st_const", st1, 1);
    tname = "load_en";
    cyc(0, 1, 0, 0, rnd(), '0);
    for (int i = 0; i < 6; i++) begin
      last = rnd();
      cyc(0, 0, 0, 1, '0, last);
    end
    cyc(0, 0, 0, 1, '0, last);
    chk("gen7_const", g0, 7);
    chk("halt7_const", h0, 1);
    sd = rnd();
    cyc(0, 0, 1, 1, sd, rnd());
    chk("seed_const", q0, sd);
    cyc(0, 0, 0, 1, '0, sd);
    tname = "saturate";
    cyc(1, 1, 0, 0, rnd(), '0);
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 1, '0, rnd());
    chk("gen15_const", g1, 15);
    chk("p0_const", p1, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
